// File: rtl/cla_pipe_addsub_if.sv
// ---------------------------------------------------------------------------
// cla_pipe_addsub_if
// Bus bundle for the pipelined carry-lookahead adder/subtractor.
//   in_valid / in_ready      : input handshake
//   data_operandA/B, subtract, Cin, in_tag : operation fields
//   out_valid / out_ready    : output handshake
//   data_result, Cout, overflow, out_tag   : result fields
// The master drives operations and consumes results; the slave is the adder.
// ---------------------------------------------------------------------------
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             subtract;
    logic             Cin;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_result;
    logic             Cout;
    logic             overflow;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, data_operandA, data_operandB, subtract, Cin, in_tag,
        output out_ready,
        input  in_ready, out_valid, data_result, Cout, overflow, out_tag
    );

    modport slave (
        input  in_valid, data_operandA, data_operandB, subtract, Cin, in_tag,
        input  out_ready,
        output in_ready, out_valid, data_result, Cout, overflow, out_tag
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// ---------------------------------------------------------------------------
// cla_pipe_addsub
// Pipelined carry-lookahead adder/subtractor. WIDTH is cut into GROUP-bit
// lookahead groups; pipeline stage k resolves group k and hands its carry to
// stage k+1 through a register, so one operation can enter every cycle.
//   result = A + (B ^ {WIDTH{subtract}}) + Cin  (mod 2^WIDTH)
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-high; discards everything in flight
//   bus    : cla_pipe_addsub_if.slave (operands, tag, handshakes, result)
// Latency is NSTAGE cycles: an op taken at edge t is presented after edge
// t+NSTAGE-1. A single global enable stalls the whole pipe when the output
// is held, so bubbles travel with the pipe rather than being squeezed out.
// ---------------------------------------------------------------------------
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8,
    parameter int TAG_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    cla_pipe_addsub_if.slave   bus
);
    localparam int NSTAGE = (GROUP >= 1) ? (WIDTH / GROUP) : 1;

    if (GROUP < 1) begin : g_chk_group
        $error("cla_pipe_addsub: GROUP must be >= 1");
    end else if ((WIDTH % GROUP) != 0) begin : g_chk_div
        $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP");
    end
    if (TAG_W < 1) begin : g_chk_tag
        $error("cla_pipe_addsub: TAG_W must be >= 1");
    end

    // Flat lookahead: every carry is a sum of generate terms gated by the
    // propagate product between them, so no carry waits on its neighbour.
    // c[i] is the carry into bit i of the group; c[GROUP] is the group carry-out.
    function automatic logic [GROUP:0] cla_carries(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             cin
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             term;
        g = a & b;
        p = a ^ b;
        c = '0;
        for (int i = 0; i <= GROUP; i++) begin
            term = cin;
            for (int m = 0; m < i; m++) begin
                term = term & p[m];
            end
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & p[m];
                end
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    // Global enable: the pipe moves whenever the output slot is empty or
    // being drained this cycle.
    logic advance;

    genvar gi;
    for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
        localparam int REM_IN_W = WIDTH - gi * GROUP;      // operand bits entering
        localparam int DONE_W   = (gi + 1) * GROUP;        // result bits leaving
        localparam int REM_W    = WIDTH - DONE_W;          // operand bits leaving

        logic [REM_IN_W-1:0] a_in;
        logic [REM_IN_W-1:0] b_in;
        logic                cin_in;
        logic [GROUP:0]      c_vec;
        logic [GROUP-1:0]    sum_d;
        logic                valid_d;
        logic [TAG_W-1:0]    tag_d;
        logic [DONE_W-1:0]   res_d;

        logic                valid_q;
        logic [TAG_W-1:0]    tag_q;
        logic                carry_q;
        logic [DONE_W-1:0]   res_q;

        if (gi == 0) begin : g_first
            // Subtraction only inverts B; the +1 comes from Cin.
            assign a_in    = bus.data_operandA;
            assign b_in    = bus.data_operandB ^ {WIDTH{bus.subtract}};
            assign cin_in  = bus.Cin;
            assign valid_d = bus.in_valid && advance;
            assign tag_d   = bus.in_tag;
            assign res_d   = sum_d;
        end else begin : g_next
            assign a_in    = g_stage[gi-1].g_rem.opa_q;
            assign b_in    = g_stage[gi-1].g_rem.opb_q;
            assign cin_in  = g_stage[gi-1].carry_q;
            assign valid_d = g_stage[gi-1].valid_q;
            assign tag_d   = g_stage[gi-1].tag_q;
            assign res_d   = {sum_d, g_stage[gi-1].res_q};
        end

        assign c_vec = cla_carries(a_in[GROUP-1:0], b_in[GROUP-1:0], cin_in);
        assign sum_d = a_in[GROUP-1:0] ^ b_in[GROUP-1:0] ^ c_vec[GROUP-1:0];

        always_ff @(posedge clock) begin
            if (reset) begin
                valid_q <= 1'b0;
                tag_q   <= '0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else if (advance) begin
                valid_q <= valid_d;
                tag_q   <= tag_d;
                carry_q <= c_vec[GROUP];
                res_q   <= res_d;
            end
        end

        if (gi < NSTAGE - 1) begin : g_rem
            // Only the operand bits of groups not yet processed move on.
            logic [REM_W-1:0] opa_q;
            logic [REM_W-1:0] opb_q;
            logic [REM_W-1:0] opa_d;
            logic [REM_W-1:0] opb_d;

            assign opa_d = a_in[REM_IN_W-1:GROUP];
            assign opb_d = b_in[REM_IN_W-1:GROUP];

            always_ff @(posedge clock) begin
                if (reset) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (advance) begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end else begin : g_last
            // The MSB is the top bit of this group, so its carry-in is local.
            logic ovf_q;
            logic ovf_d;

            assign ovf_d = c_vec[GROUP] ^ c_vec[GROUP-1];

            always_ff @(posedge clock) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign advance         = !g_stage[NSTAGE-1].valid_q || bus.out_ready;
    assign bus.in_ready    = advance;
    assign bus.out_valid   = g_stage[NSTAGE-1].valid_q;
    assign bus.data_result = g_stage[NSTAGE-1].res_q;
    assign bus.Cout        = g_stage[NSTAGE-1].carry_q;
    assign bus.overflow    = g_stage[NSTAGE-1].g_last.ovf_q;
    assign bus.out_tag     = g_stage[NSTAGE-1].tag_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_addsub
// Scoreboard bench: the expected result of every accepted operation is queued
// at acceptance and compared when the adder hands the result back.
// Also exercises GROUP=4 and GROUP=32 instances for latency and carry span.
// ---------------------------------------------------------------------------
module tb_cla_pipe_addsub;
    localparam int WIDTH  = 32;
    localparam int TAG_W  = 4;
    localparam int NSTAGE = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cla_pipe_addsub_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus   ();
    cla_pipe_addsub_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) ifc4  ();
    cla_pipe_addsub_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) ifc32 ();

    cla_pipe_addsub #(.WIDTH(WIDTH), .GROUP(8), .TAG_W(TAG_W)) u_dut (
        .clock(clock), .reset(reset), .bus(bus.slave));
    cla_pipe_addsub #(.WIDTH(WIDTH), .GROUP(4), .TAG_W(TAG_W)) u_g4 (
        .clock(clock), .reset(reset), .bus(ifc4.slave));
    cla_pipe_addsub #(.WIDTH(WIDTH), .GROUP(32), .TAG_W(TAG_W)) u_g32 (
        .clock(clock), .reset(reset), .bus(ifc32.slave));

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t cur_exp;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   lat_chk  = 1'b0;
    bit   rand_rdy = 1'b0;
    bit   accepted = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: plain 33-bit add; overflow from operand/result signs.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic cin,
                                  output logic [31:0] res, output logic cout,
                                  output logic ovf);
        logic [31:0] bx;
        logic [32:0] full;
        bx   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + {32'd0, cin};
        res  = full[31:0];
        cout = full[32];
        ovf  = (a[31] == bx[31]) && (res[31] != a[31]);
    endfunction

    // One clock: observe just after the falling edge, then advance.
    task automatic cycle();
        exp_t e;
        if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check_eq("spurious_out", bus.out_valid, 0);
                end else begin
                    e = q.pop_front();
                    $display("out  tag=%0h res=%08h cout=%0b ovf=%0b", bus.out_tag,
                             bus.data_result, bus.Cout, bus.overflow);
                    check_eq("res", bus.data_result, e.res);
                    check_eq("cout", bus.Cout, e.cout);
                    check_eq("ovf", bus.overflow, e.ovf);
                    check_eq("tag", bus.out_tag, e.tag);
                    if (lat_chk) check_eq("latency", cyc - e.acc, NSTAGE - 1);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = cur_exp;
                e.acc = cyc + 1;
                q.push_back(e);
                accepted = 1'b1;
            end
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic cin, input logic [3:0] tag, input logic [31:0] res,
                           input logic cout, input logic ovf);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.subtract      = sub;
        bus.Cin           = cin;
        bus.in_tag        = tag;
        bus.in_valid      = 1'b1;
        cur_exp.res  = res;
        cur_exp.cout = cout;
        cur_exp.ovf  = ovf;
        cur_exp.tag  = tag;
        cur_exp.acc  = 0;
    endtask

    task automatic wait_accept();
        accepted = 1'b0;
        for (int w = 0; w < 64 && !accepted; w++) cycle();
        if (!accepted) check_eq("accept_timeout", accepted, 1);
    endtask

    task automatic send_exp(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            input logic cin, input logic [3:0] tag, input logic [31:0] res,
                            input logic cout, input logic ovf);
        present(a, b, sub, cin, tag, res, cout, ovf);
        wait_accept();
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic cin, input logic [3:0] tag);
        logic [31:0] r;
        logic c, o;
        model(a, b, sub, cin, r, c, o);
        send_exp(a, b, sub, cin, tag, r, c, o);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        rand_rdy      = 1'b0;
        bus.out_ready = 1'b1;
        for (int w = 0; w < 64 && q.size() != 0; w++) cycle();
        check_eq("drain_left", q.size(), 0);
    endtask

    // Single op through the GROUP=4 and GROUP=32 instances in parallel.
    task automatic run_alt(input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic cin);
        logic [31:0] r;
        logic c, o;
        bit seen4, seen32;
        model(a, b, sub, cin, r, c, o);
        ifc4.data_operandA  = a;  ifc32.data_operandA = a;
        ifc4.data_operandB  = b;  ifc32.data_operandB = b;
        ifc4.subtract       = sub; ifc32.subtract     = sub;
        ifc4.Cin            = cin; ifc32.Cin          = cin;
        ifc4.in_tag         = 4'h5; ifc32.in_tag      = 4'h5;
        ifc4.in_valid       = 1'b1; ifc32.in_valid    = 1'b1;
        #1;
        check_eq("g4_in_ready", ifc4.in_ready, 1);
        check_eq("g32_in_ready", ifc32.in_ready, 1);
        @(posedge clock);
        cyc++;
        @(negedge clock);
        ifc4.in_valid  = 1'b0;
        ifc32.in_valid = 1'b0;
        seen4  = 1'b0;
        seen32 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            #1;
            if (ifc4.out_valid && !seen4) begin
                seen4 = 1'b1;
                $display("g4   res=%08h cout=%0b ovf=%0b lat=%0d", ifc4.data_result,
                         ifc4.Cout, ifc4.overflow, n);
                check_eq("g4_latency", n, 8);
                check_eq("g4_res", ifc4.data_result, r);
                check_eq("g4_cout", ifc4.Cout, c);
                check_eq("g4_ovf", ifc4.overflow, o);
                check_eq("g4_tag", ifc4.out_tag, 4'h5);
            end
            if (ifc32.out_valid && !seen32) begin
                seen32 = 1'b1;
                $display("g32  res=%08h cout=%0b ovf=%0b lat=%0d", ifc32.data_result,
                         ifc32.Cout, ifc32.overflow, n);
                check_eq("g32_latency", n, 1);
                check_eq("g32_res", ifc32.data_result, r);
                check_eq("g32_cout", ifc32.Cout, c);
                check_eq("g32_ovf", ifc32.overflow, o);
            end
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        check_eq("g4_seen", seen4, 1);
        check_eq("g32_seen", seen32, 1);
    endtask

    initial begin
        logic [31:0] s_res;
        logic        s_cout, s_ovf;
        logic [3:0]  s_tag;
        logic [31:0] ra, rb;

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.data_operandA = '0; bus.data_operandB = '0;
        bus.subtract = 1'b0; bus.Cin = 1'b0; bus.in_tag = '0;
        ifc4.in_valid = 1'b0; ifc4.out_ready = 1'b1;
        ifc4.data_operandA = '0; ifc4.data_operandB = '0;
        ifc4.subtract = 1'b0; ifc4.Cin = 1'b0; ifc4.in_tag = '0;
        ifc32.in_valid = 1'b0; ifc32.out_ready = 1'b1;
        ifc32.data_operandA = '0; ifc32.data_operandB = '0;
        ifc32.subtract = 1'b0; ifc32.Cin = 1'b0; ifc32.in_tag = '0;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_result", bus.data_result, 0);
        check_eq("rst_cout", bus.Cout, 0);
        check_eq("rst_ovf", bus.overflow, 0);
        check_eq("rst_tag", bus.out_tag, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_g4_valid", ifc4.out_valid, 0);

        // Carry ripples across all four groups; then signed overflow on subtract.
        lat_chk = 1'b1;
        send_exp(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h1, 32'h0000_0000, 1'b1, 1'b0);
        drain();
        send_exp(32'h8000_0000, 32'h1, 1'b1, 1'b1, 4'h2, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send_exp(32'h0000_0005, 32'h7, 1'b1, 1'b1, 4'h3, 32'hFFFF_FFFE, 1'b0, 1'b0);
        drain();

        // Back-to-back random ops at full rate.
        for (int i = 0; i < 1000; i++) begin
            ra = (i % 9 == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = (i % 11 == 0) ? 32'h0000_0001 : $urandom;
            send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
        end
        drain();

        // Full pipe with the consumer stalled for three cycles.
        lat_chk = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'(i & 1), 1'b0, 4'(8 + i));
        model(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1, s_res, s_cout, s_ovf);
        present(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1, 4'hC, s_res, s_cout, s_ovf);
        bus.out_ready = 1'b0;
        s_res = '0; s_cout = 1'b0; s_ovf = 1'b0; s_tag = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_in_ready", bus.in_ready, 0);
            check_eq("stall_valid", bus.out_valid, 1);
            if (i == 0) begin
                s_res = bus.data_result; s_cout = bus.Cout;
                s_ovf = bus.overflow;    s_tag  = bus.out_tag;
                if (q.size() > 0) check_eq("stall_front", s_res, q[0].res);
            end else begin
                check_eq("hold_res", bus.data_result, s_res);
                check_eq("hold_cout", bus.Cout, s_cout);
                check_eq("hold_ovf", bus.overflow, s_ovf);
                check_eq("hold_tag", bus.out_tag, s_tag);
            end
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        bus.out_ready = 1'b1;
        wait_accept();
        drain();

        // Reset with three ops in flight and a fourth being offered.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0, 4'(4 + i));
        present(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1, 4'h7, 32'h0, 1'b1, 1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        #1;
        check_eq("rst2_out_valid", bus.out_valid, 0);
        check_eq("rst2_in_ready", bus.in_ready, 1);
        idle(10);
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 4'hE);
        drain();

        // Random gaps and random consumer back-pressure.
        lat_chk  = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
        end
        drain();

        // Narrow and single-group configurations.
        run_alt(32'h0FFF_FFFF, 32'h1, 1'b0, 1'b0);
        run_alt(32'h8000_0000, 32'h1, 1'b1, 1'b1);
        run_alt(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
